// File: rtl/hazard_bubble_ctrl_if.sv
// Handshake bundle between the control decoder / hazard sources and the
// ID/EX control register. The master modport drives the decoder and pipeline
// inputs. The slave modport is the controller side: it receives ctrl_in,
// register specifiers, load/branch flags, flush and mc_start/mc_len, and it
// returns ctrl_out, pc_write, ifid_write, bubble and busy. It also returns
// bubble_count when PERF_CNT_EN is defined.
interface hazard_bubble_ctrl_if #(
    parameter int CTRL_W = 21,
    parameter int REG_W  = 5,
    parameter int LEN_W  = 4
`ifdef PERF_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
);
    logic [CTRL_W-1:0] ctrl_in;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic              id_uses_rt;
    logic              id_branch;
    logic              ex_memread;
    logic              ex_regwrite;
    logic [REG_W-1:0]  ex_rd;
    logic              mem_memread;
    logic [REG_W-1:0]  mem_rd;
    logic              flush;
    logic              mc_start;
    logic [LEN_W-1:0]  mc_len;
    logic [CTRL_W-1:0] ctrl_out;
    logic              pc_write;
    logic              ifid_write;
    logic              bubble;
    logic              busy;
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0]  bubble_count;
`endif

    modport master (
        output ctrl_in, id_rs, id_rt, id_uses_rt, id_branch,
        output ex_memread, ex_regwrite, ex_rd,
        output mem_memread, mem_rd, flush, mc_start, mc_len,
`ifdef PERF_CNT_EN
        input  bubble_count,
`endif
        input  ctrl_out, pc_write, ifid_write, bubble, busy
    );

    modport slave (
        input  ctrl_in, id_rs, id_rt, id_uses_rt, id_branch,
        input  ex_memread, ex_regwrite, ex_rd,
        input  mem_memread, mem_rd, flush, mc_start, mc_len,
`ifdef PERF_CNT_EN
        output bubble_count,
`endif
        output ctrl_out, pc_write, ifid_write, bubble, busy
    );
endinterface

// File: rtl/hazard_bubble_ctrl.sv
// This is the ID/EX control-bundle register. It adds load-use and
// branch-in-ID hazard bubbles, flush, and a RUN/HOLD freeze for
// long-latency EX ops.
// The plain ports are Clk and Rst (synchronous, active-high). All other
// signals go through hazard_bubble_ctrl_if.slave: ctrl_out is registered,
// while pc_write, ifid_write, bubble and busy are combinational.
// Defining the PERF_CNT_EN macro builds a saturating bubble counter
// and drives it on bubble_count.
module hazard_bubble_ctrl #(
    parameter int CTRL_W = 21,
    parameter int REG_W  = 5,
    parameter int LEN_W  = 4
`ifdef PERF_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                  Clk,
    input  logic                  Rst,
    hazard_bubble_ctrl_if.slave   bus
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    logic lu, br_ex, br_mem, haz;
    logic pc_write, ifid_write, bubble, busy;

    // r0 is hard-wired zero, so it never creates a dependency.
    function automatic logic match(
        input logic [REG_W-1:0] r,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             uses_rt
    );
        return (r != '0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    // A load feeding an ID branch stalls twice: once while the load is in
    // EX (br_ex), then again while it is in MEM (br_mem).
    always_comb begin
        lu     = bus.ex_memread &&
                 match(bus.ex_rd, bus.id_rs, bus.id_rt, bus.id_uses_rt);
        br_ex  = bus.id_branch && bus.ex_regwrite &&
                 match(bus.ex_rd, bus.id_rs, bus.id_rt, bus.id_uses_rt);
        br_mem = bus.id_branch && bus.mem_memread &&
                 match(bus.mem_rd, bus.id_rs, bus.id_rt, bus.id_uses_rt);
        haz    = lu || br_ex || br_mem;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctrl_d     = ctrl_q;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        bubble     = 1'b0;
        busy       = 1'b0;
        if (Rst) begin
            state_d = RUN;
            cnt_d   = '0;
            ctrl_d  = '0;
        end else if (bus.flush) begin
            // Squash wins over freeze; a concurrent mc_start is dropped.
            state_d    = RUN;
            cnt_d      = '0;
            ctrl_d     = '0;
            pc_write   = 1'b1;
            ifid_write = 1'b1;
        end else if (state_q == HOLD) begin
            busy  = 1'b1;
            cnt_d = cnt_q - LEN_W'(1);
            if (cnt_q <= LEN_W'(1)) begin
                state_d = RUN;
            end
        end else begin
            if (haz) begin
                ctrl_d = '0;
                bubble = 1'b1;
            end else begin
                ctrl_d     = bus.ctrl_in;
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end
            // The freeze is armed even on a bubble cycle; it starts next cycle.
            if (bus.mc_start && (bus.mc_len != '0)) begin
                state_d = HOLD;
                cnt_d   = bus.mc_len;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.ctrl_out   = ctrl_q;
    assign bus.pc_write   = pc_write;
    assign bus.ifid_write = ifid_write;
    assign bus.bubble     = bubble;
    assign bus.busy       = busy;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] bcnt_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            bcnt_q <= '0;
        end else if (bubble && (bcnt_q != '1)) begin
            bcnt_q <= bcnt_q + CNT_W'(1);
        end
    end

    assign bus.bubble_count = bcnt_q;
`endif

endmodule

// File: tb/tb_hazard_bubble_ctrl.sv
// Directed bench for hazard_bubble_ctrl.
// It covers reset, load-use, r0, load->branch, freeze, flush and reset-in-hold.
module tb_hazard_bubble_ctrl;

    localparam int CTRL_W = 21;
    localparam int REG_W  = 5;
    localparam int LEN_W  = 4;
`ifdef PERF_CNT_EN
    localparam int CNT_W  = 2;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

`ifdef PERF_CNT_EN
    hazard_bubble_ctrl_if #(
        .CTRL_W(CTRL_W), .REG_W(REG_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
    ) bus ();

    hazard_bubble_ctrl #(
        .CTRL_W(CTRL_W), .REG_W(REG_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
    ) u_dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus.slave)
    );
`else
    hazard_bubble_ctrl_if #(
        .CTRL_W(CTRL_W), .REG_W(REG_W), .LEN_W(LEN_W)
    ) bus ();

    hazard_bubble_ctrl #(
        .CTRL_W(CTRL_W), .REG_W(REG_W), .LEN_W(LEN_W)
    ) u_dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ctrl_in     = '0;
        bus.id_rs       = '0;
        bus.id_rt       = '0;
        bus.id_uses_rt  = 1'b0;
        bus.id_branch   = 1'b0;
        bus.ex_memread  = 1'b0;
        bus.ex_regwrite = 1'b0;
        bus.ex_rd       = '0;
        bus.mem_memread = 1'b0;
        bus.mem_rd      = '0;
        bus.flush       = 1'b0;
        bus.mc_start    = 1'b0;
        bus.mc_len      = '0;
    endtask

    task automatic comb(input string tag,
                        input logic pc, input logic bub, input logic bsy);
        #1;
        chk({tag, ".pc_write"},   32'(bus.pc_write),   32'(pc));
        chk({tag, ".ifid_write"}, 32'(bus.ifid_write), 32'(pc));
        chk({tag, ".bubble"},     32'(bus.bubble),     32'(bub));
        chk({tag, ".busy"},       32'(bus.busy),       32'(bsy));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle();
        bus.ctrl_in = 21'h1FFFF;
        tick();
        tick();
        chk("rst.ctrl_out", 32'(bus.ctrl_out), 32'h0);
        comb("rst", 1'b0, 1'b0, 1'b0);
`ifdef PERF_CNT_EN
        chk("rst.count", 32'(bus.bubble_count), 32'h0);
`endif

        rst = 1'b0;
        bus.ctrl_in = 21'h00123;
        comb("run0", 1'b1, 1'b0, 1'b0);
        tick();
        chk("run0.ctrl_out", 32'(bus.ctrl_out), 32'h00123);

        // load-use on rs
        bus.ex_memread = 1'b1;
        bus.ex_rd      = 5'd5;
        bus.id_rs      = 5'd5;
        bus.ctrl_in    = 21'h1ABCD;
        comb("lu", 1'b0, 1'b1, 1'b0);
        tick();
        chk("lu.ctrl_out", 32'(bus.ctrl_out), 32'h0);
        bus.ex_memread = 1'b0;
        comb("lu_gone", 1'b1, 1'b0, 1'b0);
        tick();
        chk("lu_gone.ctrl_out", 32'(bus.ctrl_out), 32'h1ABCD);

        // rt match only counts when rt is read
        idle();
        bus.ex_memread = 1'b1;
        bus.ex_rd      = 5'd9;
        bus.id_rs      = 5'd2;
        bus.id_rt      = 5'd9;
        bus.ctrl_in    = 21'h00042;
        comb("rt_unused", 1'b1, 1'b0, 1'b0);
        bus.id_uses_rt = 1'b1;
        comb("rt_used", 1'b0, 1'b1, 1'b0);

        // r0 immunity
        idle();
        bus.ex_memread = 1'b1;
        bus.ex_rd      = 5'd0;
        bus.id_rs      = 5'd0;
        bus.ctrl_in    = 21'h0F0F0;
        comb("r0", 1'b1, 1'b0, 1'b0);
        tick();
        chk("r0.ctrl_out", 32'(bus.ctrl_out), 32'h0F0F0);

        // ALU result feeding ID branch; same producer without branch is fine
        idle();
        bus.ex_regwrite = 1'b1;
        bus.ex_rd       = 5'd4;
        bus.id_rs       = 5'd4;
        bus.ctrl_in     = 21'h00777;
        comb("alu_nobr", 1'b1, 1'b0, 1'b0);
        bus.id_branch   = 1'b1;
        comb("br_ex", 1'b0, 1'b1, 1'b0);

        // load -> dependent branch: two bubbles, then release
        idle();
        bus.id_branch   = 1'b1;
        bus.id_rs       = 5'd3;
        bus.id_rt       = 5'd7;
        bus.id_uses_rt  = 1'b1;
        bus.ex_memread  = 1'b1;
        bus.ex_regwrite = 1'b1;
        bus.ex_rd       = 5'd7;
        bus.ctrl_in     = 21'h12345;
        comb("ldbr1", 1'b0, 1'b1, 1'b0);
        tick();
        bus.ex_memread  = 1'b0;
        bus.ex_regwrite = 1'b0;
        bus.ex_rd       = 5'd0;
        bus.mem_memread = 1'b1;
        bus.mem_rd      = 5'd7;
        comb("ldbr2", 1'b0, 1'b1, 1'b0);
        tick();
        chk("ldbr2.ctrl_out", 32'(bus.ctrl_out), 32'h0);
        bus.mem_memread = 1'b0;
        bus.mem_rd      = 5'd0;
        comb("ldbr3", 1'b1, 1'b0, 1'b0);
        tick();
        chk("ldbr3.ctrl_out", 32'(bus.ctrl_out), 32'h12345);

        // freeze for 3 cycles; mc_start during HOLD is ignored
        idle();
        bus.ctrl_in  = 21'h05555;
        bus.mc_start = 1'b1;
        bus.mc_len   = 4'd3;
        comb("mc_launch", 1'b1, 1'b0, 1'b0);
        tick();
        chk("hold1.ctrl_out", 32'(bus.ctrl_out), 32'h05555);
        bus.mc_start = 1'b0;
        bus.ctrl_in  = 21'h1FFFF;
        comb("hold1", 1'b0, 1'b0, 1'b1);
        bus.mc_start = 1'b1;
        bus.mc_len   = 4'd5;
        tick();
        bus.mc_start = 1'b0;
        chk("hold2.ctrl_out", 32'(bus.ctrl_out), 32'h05555);
        comb("hold2", 1'b0, 1'b0, 1'b1);
        tick();
        chk("hold3.ctrl_out", 32'(bus.ctrl_out), 32'h05555);
        comb("hold3", 1'b0, 1'b0, 1'b1);
        tick();
        chk("unfrz.ctrl_out", 32'(bus.ctrl_out), 32'h05555);
        comb("unfrz", 1'b1, 1'b0, 1'b0);
        tick();
        chk("unfrz.ctrl_next", 32'(bus.ctrl_out), 32'h1FFFF);

        // mc_len == 0 never enters HOLD
        bus.mc_start = 1'b1;
        bus.mc_len   = 4'd0;
        bus.ctrl_in  = 21'h00ABC;
        tick();
        bus.mc_start = 1'b0;
        comb("len0", 1'b1, 1'b0, 1'b0);

        // flush during HOLD with cnt == 2
        bus.mc_start = 1'b1;
        bus.mc_len   = 4'd3;
        tick();
        bus.mc_start = 1'b0;
        tick();
        comb("pre_flush", 1'b0, 1'b0, 1'b1);
        bus.flush = 1'b1;
        #1;
        chk("flush_hold.pc_write", 32'(bus.pc_write), 32'h1);
        chk("flush_hold.bubble",   32'(bus.bubble),   32'h0);
        tick();
        bus.flush = 1'b0;
        chk("flush_hold.ctrl_out", 32'(bus.ctrl_out), 32'h0);
        comb("post_flush", 1'b1, 1'b0, 1'b0);

        // flush + hazard + mc_start together
        idle();
        bus.flush      = 1'b1;
        bus.ex_memread = 1'b1;
        bus.ex_rd      = 5'd6;
        bus.id_rs      = 5'd6;
        bus.mc_start   = 1'b1;
        bus.mc_len     = 4'd3;
        bus.ctrl_in    = 21'h13579;
        comb("flush_all", 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        bus.ctrl_in = 21'h02468;
        chk("flush_all.ctrl_out", 32'(bus.ctrl_out), 32'h0);
        comb("flush_all_next", 1'b1, 1'b0, 1'b0);
        tick();
        chk("flush_all.ctrl_next", 32'(bus.ctrl_out), 32'h02468);

`ifdef PERF_CNT_EN
        // saturating bubble counter (CNT_W = 2)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        bus.ex_memread = 1'b1;
        bus.ex_rd      = 5'd8;
        bus.id_rs      = 5'd8;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("cnt%0d", i), 32'(bus.bubble_count),
                (i < 3) ? 32'(i + 1) : 32'd3);
        end
        idle();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("cnt_flush", 32'(bus.bubble_count), 32'd3);
`endif

        // reset in the middle of HOLD
        idle();
        bus.ctrl_in  = 21'h0BEEF;
        bus.mc_start = 1'b1;
        bus.mc_len   = 4'd4;
        tick();
        bus.mc_start = 1'b0;
        chk("rsthold.pre_ctrl", 32'(bus.ctrl_out), 32'h0BEEF);
        rst = 1'b1;
        comb("rsthold", 1'b0, 1'b0, 1'b0);
        tick();
        chk("rsthold.ctrl_out", 32'(bus.ctrl_out), 32'h0);
`ifdef PERF_CNT_EN
        chk("rsthold.count", 32'(bus.bubble_count), 32'h0);
`endif
        rst = 1'b0;
        comb("rsthold_rel", 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
